// File: rtl/ppu_vec_quant_if.sv
// Handshake bundle between the MAC array, the vector quantizer and the activation SRAM writer.
// slave is the quantizer's view; master is the view of the surrounding producer/consumer.
interface ppu_vec_quant_if #(
   parameter int LANES   = 16,
   parameter int PSUM_W  = 24,
   parameter int SCALE_W = 8,
   parameter int BIAS_W  = 8,
   parameter int OUT_W   = 8
);
   localparam int Y_W  = PSUM_W + SCALE_W + 2;
   localparam int SH_W = $clog2(Y_W) + 1;

   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*PSUM_W-1:0]   psum;
   logic [SCALE_W-1:0]        scale;
   logic [BIAS_W-1:0]         bias;
   logic                      relu_en;
   logic                      out_valid;
   logic                      out_ready;
   logic [LANES*OUT_W-1:0]    out_data;
   logic [SH_W-1:0]           out_shift;
   logic                      out_sat;

   modport slave (
      input  in_valid, psum, scale, bias, relu_en, out_ready,
      output in_ready, out_valid, out_data, out_shift, out_sat
   );

   modport master (
      output in_valid, psum, scale, bias, relu_en, out_ready,
      input  in_ready, out_valid, out_data, out_shift, out_sat
   );
endinterface

// File: rtl/ppu_vec_quant.sv
// Scale, bias and optional ReLU on a psum vector, then power-of-two block quantization to OUT_W bits.
// out_valid rises 3 cycles after accept; result is held for any out_ready backpressure, one vector in flight.
module ppu_vec_quant #(
   parameter int LANES      = 16,
   parameter int PSUM_W     = 24,
   parameter int SCALE_W    = 8,
   parameter int SCALE_FRAC = 4,
   parameter int BIAS_W     = 8,
   parameter int OUT_W      = 8
) (
   input  logic           clk,
   input  logic           rst,
   ppu_vec_quant_if.slave bus
);
   localparam int Y_W   = PSUM_W + SCALE_W + 2;
   localparam int SH_W  = $clog2(Y_W) + 1;
   localparam int S_MAX = Y_W - OUT_W;
   localparam int Q_MAX = (1 << (OUT_W - 1)) - 1;
   localparam logic signed [Y_W:0] R_HI = (Y_W+1)'(Q_MAX);
   localparam logic signed [Y_W:0] R_LO = -R_HI;

   typedef enum logic [2:0] {IDLE, SCALE, REDUCE, QUANT, OUTPUT} state_t;
   state_t state, state_nxt;

   logic [LANES-1:0][PSUM_W-1:0] psum_r;
   logic [SCALE_W-1:0]           scale_r;
   logic [BIAS_W-1:0]            bias_r;
   logic                         relu_r;
   logic [LANES-1:0][Y_W-1:0]    y_r, y_nxt;
   logic [SH_W-1:0]              s_r, s_nxt;
   logic [LANES-1:0][OUT_W-1:0]  q_r, q_nxt;
   logic [SH_W-1:0]              shift_r;
   logic                         sat_r, sat_nxt;
   logic [Y_W-1:0]               m, mag;
   logic signed [Y_W-1:0]        prod, y;
   logic signed [Y_W:0]          yw, rnd, r;
   logic                         accept;

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = (state == OUTPUT);
   assign bus.out_data  = q_r;
   assign bus.out_shift = shift_r;
   assign bus.out_sat   = sat_r;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SCALE;
         SCALE:   state_nxt = REDUCE;
         REDUCE:  state_nxt = QUANT;
         QUANT:   state_nxt = OUTPUT;
         OUTPUT:  if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Y_W leaves headroom for the full signed product plus bias, so no lane can wrap here.
   always_comb begin
      y_nxt = '0;
      prod  = '0;
      y     = '0;
      for (int i = 0; i < LANES; i++) begin
         prod = $signed({{(Y_W-PSUM_W){psum_r[i][PSUM_W-1]}}, psum_r[i]})
              * $signed({{(Y_W-SCALE_W){1'b0}}, scale_r});
         y    = (prod >>> SCALE_FRAC) + $signed({{(Y_W-BIAS_W){bias_r[BIAS_W-1]}}, bias_r});
         if (relu_r && y[Y_W-1]) y = '0;
         y_nxt[i] = y;
      end
   end

   always_comb begin
      m     = '0;
      mag   = '0;
      s_nxt = SH_W'(S_MAX);
      for (int i = 0; i < LANES; i++) begin
         mag = y_r[i][Y_W-1] ? (~y_r[i]) + Y_W'(1) : y_r[i];
         if (mag > m) m = mag;
      end
      // Scan downwards so the last hit is the smallest exponent that fits.
      for (int k = S_MAX; k >= 0; k--) begin
         if ((m >> k) <= Y_W'(Q_MAX)) s_nxt = SH_W'(k);
      end
   end

   // Round half up then clip to the symmetric range, so the most negative code never appears.
   always_comb begin
      q_nxt   = '0;
      sat_nxt = 1'b0;
      yw      = '0;
      rnd     = '0;
      r       = '0;
      for (int i = 0; i < LANES; i++) begin
         yw = {y_r[i][Y_W-1], y_r[i]};
         if (s_r == '0) begin
            r = yw;
         end else begin
            rnd = (Y_W+1)'(1) << (s_r - SH_W'(1));
            r   = (yw + rnd) >>> s_r;
         end
         if (r > R_HI) begin
            q_nxt[i] = R_HI[OUT_W-1:0];
            sat_nxt  = 1'b1;
         end else if (r < R_LO) begin
            q_nxt[i] = R_LO[OUT_W-1:0];
            sat_nxt  = 1'b1;
         end else begin
            q_nxt[i] = r[OUT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         psum_r  <= '0;
         scale_r <= '0;
         bias_r  <= '0;
         relu_r  <= 1'b0;
         y_r     <= '0;
         s_r     <= '0;
         q_r     <= '0;
         shift_r <= '0;
         sat_r   <= 1'b0;
      end else begin
         if (accept) begin
            psum_r  <= bus.psum;
            scale_r <= bus.scale;
            bias_r  <= bus.bias;
            relu_r  <= bus.relu_en;
         end
         if (state == SCALE)  y_r <= y_nxt;
         if (state == REDUCE) s_r <= s_nxt;
         if (state == QUANT) begin
            q_r     <= q_nxt;
            shift_r <= s_r;
            sat_r   <= sat_nxt;
         end
      end
   end
endmodule

// File: tb/tb_ppu_vec_quant.sv
// Bench for ppu_vec_quant: directed corner vectors, backpressure, mid-flight reset, then random vectors
// checked against an integer-arithmetic reference model.
module tb_ppu_vec_quant;
   localparam int LANES      = 16;
   localparam int PSUM_W     = 24;
   localparam int SCALE_W    = 8;
   localparam int SCALE_FRAC = 4;
   localparam int BIAS_W     = 8;
   localparam int OUT_W      = 8;
   localparam int Y_W        = PSUM_W + SCALE_W + 2;
   localparam int Q_MAX      = (1 << (OUT_W - 1)) - 1;

   typedef longint vec_t [LANES];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ppu_vec_quant_if #(.LANES(LANES), .PSUM_W(PSUM_W), .SCALE_W(SCALE_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) bus ();

   ppu_vec_quant #(
      .LANES(LANES), .PSUM_W(PSUM_W), .SCALE_W(SCALE_W),
      .SCALE_FRAC(SCALE_FRAC), .BIAS_W(BIAS_W), .OUT_W(OUT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint fdiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   // Reference: exact integer arithmetic with floor division, straight from the quantization rules.
   task automatic model(input vec_t p, input int sc, input int bi, input bit re,
                        output logic [127:0] q, output int s, output bit sat);
      longint y [LANES];
      longint m, r, a;
      m = 0; q = '0; sat = 1'b0; s = 0;
      for (int i = 0; i < LANES; i++) begin
         y[i] = fdiv(p[i] * sc, longint'(1) << SCALE_FRAC) + bi;
         if (re && y[i] < 0) y[i] = 0;
         a = (y[i] < 0) ? -y[i] : y[i];
         if (a > m) m = a;
      end
      while (s < Y_W - OUT_W && fdiv(m, longint'(1) << s) > Q_MAX) s++;
      for (int i = 0; i < LANES; i++) begin
         if (s == 0) r = y[i];
         else        r = fdiv(y[i] + (longint'(1) << (s - 1)), longint'(1) << s);
         if (r > Q_MAX) begin
            r = Q_MAX; sat = 1'b1;
         end else if (r < -Q_MAX) begin
            r = -Q_MAX; sat = 1'b1;
         end
         q[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
      end
   endtask

   task automatic drive(input vec_t p, input int sc, input int bi, input bit re);
      for (int i = 0; i < LANES; i++) bus.psum[i*PSUM_W +: PSUM_W] = PSUM_W'(p[i]);
      bus.scale    = SCALE_W'(sc);
      bus.bias     = BIAS_W'(bi);
      bus.relu_en  = re;
      bus.in_valid = 1'b1;
   endtask

   task automatic offer(input string tag, input vec_t p, input int sc, input int bi, input bit re);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " in_ready"}, bus.in_ready, 1);
      drive(p, sc, bi, re);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   // Entered just after the accept edge; counts edges until out_valid.
   task automatic expect_out(input string tag, input logic [127:0] eq, input int es, input bit esat);
      int lat;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.out_valid) break;
      end
      chk({tag, " latency"}, lat, 3);
      chk({tag, " data"}, bus.out_data, eq);
      chk({tag, " shift"}, bus.out_shift, es);
      chk({tag, " sat"}, bus.out_sat, esat);
   endtask

   task automatic release_out(input string tag, input int hold, input logic [127:0] eq, input int es, input bit esat);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, " hold valid"}, bus.out_valid, 1);
         chk({tag, " hold data"}, bus.out_data, eq);
         chk({tag, " hold shift"}, bus.out_shift, es);
         chk({tag, " hold sat"}, bus.out_sat, esat);
         chk({tag, " hold in_ready"}, bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      chk({tag, " post valid"}, bus.out_valid, 0);
      chk({tag, " post in_ready"}, bus.in_ready, 1);
      chk({tag, " post data kept"}, bus.out_data, eq);
      chk({tag, " post shift kept"}, bus.out_shift, es);
   endtask

   task automatic run(input string tag, input vec_t p, input int sc, input int bi, input bit re, input int hold);
      logic [127:0] eq;
      int es;
      bit esat;
      model(p, sc, bi, re, eq, es, esat);
      offer(tag, p, sc, bi, re);
      expect_out(tag, eq, es, esat);
      release_out(tag, hold, eq, es, esat);
   endtask

   task automatic fill(output vec_t p, input longint v);
      for (int i = 0; i < LANES; i++) p[i] = v;
   endtask

   task automatic rand_vec(output vec_t p);
      int bits;
      longint v;
      bits = $urandom_range(1, PSUM_W - 1);
      for (int i = 0; i < LANES; i++) begin
         v = longint'($urandom_range(0, (1 << bits) - 1));
         if ($urandom_range(0, 1) == 1) v = -v;
         p[i] = v;
      end
   endtask

   initial begin
      vec_t p, p2;
      logic [127:0] eq, eq2;
      int es, es2;
      bit esat, esat2;
      bit seen;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.psum      = '0;
      bus.scale     = '0;
      bus.bias      = '0;
      bus.relu_en   = 1'b0;

      // Reset with a vector offered: it must not be taken.
      fill(p, 1000);
      drive(p, 16, 0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset in_ready", bus.in_ready, 0);
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset out_data", bus.out_data, 0);
      chk("reset out_shift", bus.out_shift, 0);
      chk("reset out_sat", bus.out_sat, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("after reset in_ready", bus.in_ready, 1);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      chk("no output from reset-time offer", seen, 0);

      fill(p, 1000);
      run("t1 all1000", p, 16, 0, 1'b0, 0);
      fill(p, 100); p[0] = -1000;
      run("t2 mixed", p, 16, 0, 1'b0, 1);
      run("t2 mixed relu", p, 16, 0, 1'b1, 0);
      fill(p, 5);
      run("t3 bias", p, 16, 2, 1'b0, 0);
      fill(p, 3);
      run("t3 floor", p, 8, 0, 1'b0, 0);
      fill(p, 0); p[0] = 255;
      run("t4 clip", p, 16, 0, 1'b0, 2);
      fill(p, 0);
      run("zero vec", p, 200, 0, 1'b0, 0);
      fill(p, -8388608);
      run("max neg", p, 255, -128, 1'b0, 0);

      // Backpressure with a second vector waiting on the input.
      fill(p, 1000);
      model(p, 16, 0, 1'b0, eq, es, esat);
      rand_vec(p2);
      model(p2, 37, -5, 1'b0, eq2, es2, esat2);
      offer("t5 first", p, 16, 0, 1'b0);
      expect_out("t5 first", eq, es, esat);
      drive(p2, 37, -5, 1'b0);
      release_out("t5 first", 10, eq, es, esat);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      expect_out("t5 second", eq2, es2, esat2);
      release_out("t5 second", 0, eq2, es2, esat2);

      // Reset while the vector sits in REDUCE.
      fill(p, 1000);
      offer("t6 dropped", p, 16, 0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t6 rst out_valid", bus.out_valid, 0);
      chk("t6 rst out_data", bus.out_data, 0);
      chk("t6 rst out_shift", bus.out_shift, 0);
      chk("t6 rst out_sat", bus.out_sat, 0);
      chk("t6 rst in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6 in_ready after rst", bus.in_ready, 1);
      fill(p, 100); p[3] = -1000;
      run("t6 recover", p, 16, 3, 1'b0, 0);

      for (int t = 0; t < 30; t++) begin
         rand_vec(p);
         run($sformatf("rand%0d", t), p, $urandom_range(0, 255), $urandom_range(0, 255) - 128,
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
